dac_tri_gen: RTL and testbench

Transmit-side waveform source for the SWIPT PLL test path. It drives a 12-bit offset-binary DAC code with an amplitude-scaled triangle wave from an NCO phase accumulator; the ADC/comparator path closes the loop on the receive side. Amplitude ramps up when `swiptAlive` asserts and ramps down to mid-scale when it drops, so the DAC never steps abruptly.

---
 rtl/dac_tri_gen_if.sv | 27 ++
 rtl/dac_tri_gen.sv | 165 ++++++++++++++++
 tb/tb_dac_tri_gen.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_tri_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_tri_gen_if
// Purpose  : Control and DAC-side bundle for the triangle waveform source.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_tri_gen_if #(
    parameter int ACC_W = 24
);
    logic             swiptAlive;
    logic [ACC_W-1:0] fcw;
    logic [8:0]       amp_tgt;
    logic [11:0]      dac_code;
    logic             dac_active;
    logic             phase_wrap;

    modport master (
        output swiptAlive, fcw, amp_tgt,
        input  dac_code, dac_active, phase_wrap
    );

    modport slave (
        input  swiptAlive, fcw, amp_tgt,
        output dac_code, dac_active, phase_wrap
    );
endinterface
`default_nettype wire

// File: rtl/dac_tri_gen.sv
`default_nettype none
// ============================================================================
// Module   : dac_tri_gen
// Purpose  : NCO-driven, amplitude-ramped triangle source for a 12-bit
//            offset-binary DAC.
// Revision : 1.0 - initial release
// ============================================================================
module dac_tri_gen #(
    parameter int ACC_W    = 24,
    parameter int RAMP_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    dac_tri_gen_if.slave bus
);
    localparam int                 c_DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RAMP_DIV - 1);
    localparam logic [8:0]         c_AMP_FULL = 9'd256;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [8:0]         r_amp_cur;
    logic [8:0]         w_amp_nxt;
    logic [8:0]         r_amp_lat;
    logic [8:0]         w_lat_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic [ACC_W-1:0]   r_phase;
    logic [11:0]        r_dac_code;
    logic               r_dac_active;
    logic               r_phase_wrap;

    logic               w_div_term;
    logic [c_DIV_W-1:0] w_div_inc;
    logic [8:0]         w_amp_clamp;
    logic [ACC_W:0]     w_sum;
    logic [11:0]        w_p;
    logic signed [11:0] w_tri;
    logic signed [22:0] w_tri2;
    logic signed [22:0] w_amp_ext;
    logic signed [22:0] w_prod;
    logic [11:0]        w_dac;
    logic               w_unused;

    assign w_div_term  = (r_div_cnt == c_DIV_LAST);
    assign w_div_inc   = r_div_cnt + c_DIV_W'(1);
    assign w_amp_clamp = (bus.amp_tgt > c_AMP_FULL) ? c_AMP_FULL : bus.amp_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A ramp leaves on the same edge that makes its last amplitude step, so
    // each ramp lasts exactly amplitude*RAMP_DIV cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp_cur;
        w_div_nxt   = r_div_cnt;
        w_lat_nxt   = r_amp_lat;
        case (r_state)
            S_IDLE: begin
                w_amp_nxt = '0;
                w_div_nxt = '0;
                if (bus.swiptAlive) begin
                    w_state_nxt = S_RAMP_UP;
                    w_lat_nxt   = w_amp_clamp;
                end
            end
            S_RAMP_UP: begin
                if (!bus.swiptAlive) begin
                    w_state_nxt = S_RAMP_DOWN;
                    w_div_nxt   = '0;
                end else if (r_amp_cur == r_amp_lat) begin
                    w_state_nxt = S_RUN;
                    w_div_nxt   = '0;
                end else if (w_div_term) begin
                    w_amp_nxt = r_amp_cur + 9'd1;
                    w_div_nxt = '0;
                    if (r_amp_cur + 9'd1 == r_amp_lat) begin
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_div_nxt = w_div_inc;
                end
            end
            S_RUN: begin
                w_div_nxt = '0;
                if (!bus.swiptAlive) begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (r_amp_cur == 9'd0) begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                end else if (w_div_term) begin
                    w_amp_nxt = r_amp_cur - 9'd1;
                    w_div_nxt = '0;
                    if (r_amp_cur == 9'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_div_nxt = w_div_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_sum = {1'b0, r_phase} + {1'b0, bus.fcw};
    assign w_p   = r_phase[ACC_W-1 -: 12];
    assign w_tri = w_p[11] ? (12'sd1023 - $signed({1'b0, w_p[10:0]}))
                           : ($signed({1'b0, w_p[10:0]}) - 12'sd1024);

    // Product of 2*tri and amplitude always fits in 20 bits; bits [19:8] are
    // the floor-shifted level, which is at most 11 bits plus sign.
    assign w_tri2    = {{10{w_tri[11]}}, w_tri, 1'b0};
    assign w_amp_ext = {14'd0, r_amp_cur};
    assign w_prod    = w_tri2 * w_amp_ext;
    assign w_dac     = 12'h800 + w_prod[19:8];
    assign w_unused  = &{1'b0, w_prod[22:20], w_prod[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_amp_cur    <= '0;
            r_amp_lat    <= '0;
            r_div_cnt    <= '0;
            r_phase      <= '0;
            r_dac_code   <= 12'h800;
            r_dac_active <= 1'b0;
            r_phase_wrap <= 1'b0;
        end else begin
            r_amp_cur    <= w_amp_nxt;
            r_amp_lat    <= w_lat_nxt;
            r_div_cnt    <= w_div_nxt;
            r_dac_active <= (w_state_nxt != S_IDLE);
            r_dac_code   <= (r_state == S_IDLE) ? 12'h800 : w_dac;
            if ((r_state != S_IDLE) && (w_state_nxt != S_IDLE)) begin
                r_phase      <= w_sum[ACC_W-1:0];
                r_phase_wrap <= w_sum[ACC_W];
            end else begin
                r_phase      <= '0;
                r_phase_wrap <= 1'b0;
            end
        end
    end

    assign bus.dac_code   = r_dac_code;
    assign bus.dac_active = r_dac_active;
    assign bus.phase_wrap = r_phase_wrap;
endmodule
`default_nettype wire

// File: tb/tb_dac_tri_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_tri_gen
// Purpose  : Randomized bench for dac_tri_gen against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_tri_gen;
    localparam int ACC_W = 24;
    localparam int RD    = 4;
    localparam int MI = 0, MU = 1, MR = 2, MD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // model state: mode, phase, amplitude, latched target, ramp bookkeeping
    int   m_mode, m_phase, m_amp, m_lat, m_el, m_start, m_dac;
    logic m_act, m_wrap;

    always #5 clk = ~clk;

    dac_tri_gen_if #(.ACC_W(ACC_W)) bus ();

    dac_tri_gen #(.ACC_W(ACC_W), .RAMP_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int scale(input int ph, input int a);
        int p, t, v;
        p = ph >> (ACC_W - 12);
        t = (p < 2048) ? p - 1024 : 3071 - p;
        v = 2 * t * a;
        return (v >= 0) ? v / 256 : -((-v + 255) / 256);
    endfunction

    // Advance model by one edge using the inputs the DUT samples, then wait
    // until the negedge after that edge.
    task automatic tick();
        int old, s, d, tgt, f;
        tgt = int'(bus.amp_tgt);
        f   = int'(bus.fcw);
        if (rst) begin
            m_mode = MI; m_phase = 0; m_amp = 0; m_el = 0; m_start = 0;
            m_dac = 2048; m_act = 1'b0; m_wrap = 1'b0;
        end else begin
            d   = (m_mode == MI) ? 2048 : 2048 + scale(m_phase, m_amp);
            old = m_mode;
            case (m_mode)
                MI: if (bus.swiptAlive) begin
                        m_lat = (tgt > 256) ? 256 : tgt; m_mode = MU; m_el = 0;
                    end
                MU: if (!bus.swiptAlive) begin
                        m_mode = MD; m_start = m_amp; m_el = 0;
                    end else if (m_lat == 0) begin
                        m_mode = MR;
                    end else begin
                        m_el++; m_amp = m_el / RD;
                        if (m_el == m_lat * RD) m_mode = MR;
                    end
                MR: if (!bus.swiptAlive) begin
                        m_mode = MD; m_start = m_amp; m_el = 0;
                    end
                default: if (m_start == 0) begin
                        m_mode = MI;
                    end else begin
                        m_el++; m_amp = m_start - m_el / RD;
                        if (m_el == m_start * RD) m_mode = MI;
                    end
            endcase
            if (old != MI && m_mode != MI) begin
                s = m_phase + f;
                m_wrap  = (s >= (1 << ACC_W));
                m_phase = s & ((1 << ACC_W) - 1);
            end else begin
                m_phase = 0; m_wrap = 1'b0;
            end
            if (m_mode == MI) m_amp = 0;
            m_act = (m_mode != MI);
            m_dac = d;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bus.swiptAlive = 1'b0;
        for (int i = 0; i < 3000 && m_mode != MI; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.swiptAlive = 1'b1;
        bus.fcw = ACC_W'(32'h100000); bus.amp_tgt = 9'd256;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.dac_code !== 12'h800 || bus.dac_active !== 1'b0 || bus.phase_wrap !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: dac=%h act=%b wrap=%b, need 800/0/0",
                         bus.dac_code, bus.dac_active, bus.phase_wrap);
            end
        end
        rst = 1'b0; bus.swiptAlive = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (bus.dac_code !== 12'h800 || bus.dac_active !== 1'b0 || bus.phase_wrap !== 1'b0) begin
                bad++;
                $display("FAIL idle: dac=%h act=%b wrap=%b, need 800/0/0",
                         bus.dac_code, bus.dac_active, bus.phase_wrap);
            end
        end
    endtask

    task automatic test_full_ramp();
        int mx, mn, prev;
        mx = 0; mn = 4095; prev = -1;
        bus.amp_tgt = 9'd256; bus.fcw = ACC_W'(32'h100000); bus.swiptAlive = 1'b1;
        for (int i = 0; i < 1164; i++) begin
            tick();
            total++;
            if (bus.dac_code !== 12'(m_dac) || bus.dac_active !== m_act || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL full_ramp cyc%0d: dac=%h act=%b wrap=%b, need %h/%b/%b",
                         i, bus.dac_code, bus.dac_active, bus.phase_wrap, m_dac[11:0], m_act, m_wrap);
            end
            if (i >= 1100) begin
                if (int'(bus.dac_code) > mx) mx = int'(bus.dac_code);
                if (int'(bus.dac_code) < mn) mn = int'(bus.dac_code);
                if (bus.phase_wrap === 1'b1) begin
                    if (prev >= 0) begin
                        total++;
                        if (i - prev != 16) begin
                            bad++;
                            $display("FAIL wrap_period: got %0d cycles, need 16", i - prev);
                        end
                    end
                    prev = i;
                end
            end
        end
        total++;
        if (mx != 12'hFFE || mn != 0) begin
            bad++;
            $display("FAIL full_peaks: max=%h min=%h, need FFE/000", mx, mn);
        end
        total++;
        if (prev < 0) begin
            bad++;
            $display("FAIL wrap_seen: no phase_wrap pulse in RUN, need pulses");
        end
    endtask

    task automatic test_abort();
        int cnt;
        drain();
        bus.amp_tgt = 9'($urandom_range(101, 300));
        bus.fcw = ACC_W'($urandom);
        bus.swiptAlive = 1'b1;
        for (int i = 0; i < 2000 && !(m_mode == MU && m_amp == 100); i++) begin
            tick();
            total++;
            if (bus.dac_code !== 12'(m_dac) || bus.dac_active !== m_act || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL abort_up: dac=%h act=%b wrap=%b, need %h/%b/%b",
                         bus.dac_code, bus.dac_active, bus.phase_wrap, m_dac[11:0], m_act, m_wrap);
            end
        end
        bus.swiptAlive = 1'b0;
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 50) bus.swiptAlive = 1'b1;
            tick();
            total++;
            if (bus.dac_code !== 12'(m_dac) || bus.dac_active !== m_act || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL abort_down: dac=%h act=%b wrap=%b, need %h/%b/%b",
                         bus.dac_code, bus.dac_active, bus.phase_wrap, m_dac[11:0], m_act, m_wrap);
            end
            if (bus.dac_active !== 1'b1) break;
            cnt++;
        end
        total++;
        if (cnt != 400) begin
            bad++;
            $display("FAIL abort_len: ramp-down lasted %0d cycles, need 400", cnt);
        end
        tick();
        total++;
        if (bus.dac_code !== 12'h800 || bus.dac_active !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: dac=%h act=%b, need 800/1", bus.dac_code, bus.dac_active);
        end
    endtask

    task automatic test_clamp_latch();
        int mx;
        mx = 0;
        drain();
        bus.amp_tgt = 9'd400; bus.fcw = ACC_W'(32'h100000); bus.swiptAlive = 1'b1;
        for (int i = 0; i < 1164; i++) begin
            if (i == 1100) bus.amp_tgt = 9'd10;
            tick();
            total++;
            if (bus.dac_code !== 12'(m_dac) || bus.dac_active !== m_act || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL clamp cyc%0d: dac=%h act=%b wrap=%b, need %h/%b/%b",
                         i, bus.dac_code, bus.dac_active, bus.phase_wrap, m_dac[11:0], m_act, m_wrap);
            end
            if (i > 1100 && int'(bus.dac_code) > mx) mx = int'(bus.dac_code);
        end
        total++;
        if (mx != 12'hFFE) begin
            bad++;
            $display("FAIL clamp_peak: max=%h, need FFE", mx);
        end
    endtask

    task automatic test_zero_amp();
        drain();
        bus.amp_tgt = 9'd0; bus.fcw = ACC_W'($urandom); bus.swiptAlive = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (bus.dac_code !== 12'h800 || bus.dac_active !== 1'b1 || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL zero_amp cyc%0d: dac=%h act=%b wrap=%b, need 800/1/%b",
                         i, bus.dac_code, bus.dac_active, bus.phase_wrap, m_wrap);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drain();
        bus.amp_tgt = 9'($urandom_range(20, 60)); bus.fcw = ACC_W'($urandom); bus.swiptAlive = 1'b1;
        for (int i = 0; i < 1000 && m_mode != MR; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (bus.dac_code !== 12'h800 || bus.dac_active !== 1'b0 || bus.phase_wrap !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: dac=%h act=%b wrap=%b, need 800/0/0",
                     bus.dac_code, bus.dac_active, bus.phase_wrap);
        end
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            total++;
            if (bus.dac_code !== 12'(m_dac) || bus.dac_active !== m_act || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL restart cyc%0d: dac=%h act=%b wrap=%b, need %h/%b/%b",
                         i, bus.dac_code, bus.dac_active, bus.phase_wrap, m_dac[11:0], m_act, m_wrap);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.swiptAlive = ~bus.swiptAlive;
            if ($urandom_range(0, 199) == 0) bus.amp_tgt = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 99) == 0)
                bus.fcw = ($urandom_range(0, 3) == 0) ? '0 : ACC_W'($urandom);
            tick();
            total++;
            if (bus.dac_code !== 12'(m_dac) || bus.dac_active !== m_act || bus.phase_wrap !== m_wrap) begin
                bad++;
                $display("FAIL random cyc%0d: dac=%h act=%b wrap=%b, need %h/%b/%b",
                         i, bus.dac_code, bus.dac_active, bus.phase_wrap, m_dac[11:0], m_act, m_wrap);
            end
        end
    endtask

    initial begin
        bus.swiptAlive = 1'b0;
        bus.fcw        = '0;
        bus.amp_tgt    = '0;
        m_mode = MI; m_phase = 0; m_amp = 0; m_lat = 0; m_el = 0; m_start = 0;
        m_dac = 2048; m_act = 1'b0; m_wrap = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_ramp();
        test_abort();
        test_clamp_latch();
        test_zero_amp();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
